// File: rtl/delay_line_pkg.sv
// Shared constants and FSM encoding for the delay_line sequencing controller.
package delay_line_pkg;

    localparam int DELAY_W = 4;
    localparam int DEPTH   = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/valid_mirror.sv
// Valid-bit shadow of the SRL16 datapath: shifts every cycle like the shift cells,
// so the bit selected by the tap tells whether dout carries an accepted sample.
module valid_mirror
    import delay_line_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift_in,
    input  logic               clear,
    input  logic [DELAY_W-1:0] tap,
    output logic               out_valid,
    output logic               drain_empty
);

    logic [DEPTH-1:0] vld_sr_reg;
    logic [DEPTH-1:0] tap_mask;

    // Inclusive mask over positions 0..tap; bits above the tap have already been emitted.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
            assign tap_mask[gi] = (DELAY_W'(gi) <= tap);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr_reg <= '0;
        end else if (clear) begin
            vld_sr_reg <= '0;
        end else begin
            vld_sr_reg <= {vld_sr_reg[DEPTH-2:0], shift_in};
        end
    end

    assign out_valid   = vld_sr_reg[tap];
    assign drain_empty = ~|(vld_sr_reg & tap_mask);

endmodule

// File: rtl/delay_line_ctrl.sv
// Sequencing controller for the SRL16 delay_line: owns the tap select, tracks sample
// validity, and applies delay changes by stalling, draining, switching and clearing.
module delay_line_ctrl
    import delay_line_pkg::*;
#(
    parameter int DEFAULT_DELAY = 0,
    parameter bit DRAIN_EN      = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DELAY_W-1:0] delay,
    output logic               out_valid,
    output logic               busy,
    output logic               cfg_done
);

    ctrl_state_t        state_reg;
    logic [DELAY_W-1:0] delay_reg;
    logic [DELAY_W-1:0] pend_reg;
    logic               ready_reg;
    logic               busy_reg;
    logic               cfg_done_reg;
    logic               drain_empty;
    logic               sample_fire;
    logic               cfg_fire;

    assign sample_fire = in_valid & ready_reg;
    assign cfg_fire    = cfg_valid & ready_reg;

    valid_mirror u_mirror (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift_in    (sample_fire),
        .clear       (state_reg == SWITCH),
        .tap         (delay_reg),
        .out_valid   (out_valid),
        .drain_empty (drain_empty)
    );

    // ready/busy are registered alongside the state so they are glitch-free outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            delay_reg    <= DELAY_W'(DEFAULT_DELAY);
            pend_reg     <= '0;
            ready_reg    <= 1'b1;
            busy_reg     <= 1'b0;
            cfg_done_reg <= 1'b0;
        end else begin
            cfg_done_reg <= 1'b0;
            case (state_reg)
                RUN: begin
                    if (cfg_fire && (cfg_delay != delay_reg)) begin
                        pend_reg  <= cfg_delay;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        if (DRAIN_EN) state_reg <= DRAIN;
                        else          state_reg <= SWITCH;
                    end
                end
                DRAIN: begin
                    if (drain_empty) state_reg <= SWITCH;
                end
                SWITCH: begin
                    delay_reg    <= pend_reg;
                    state_reg    <= RUN;
                    ready_reg    <= 1'b1;
                    busy_reg     <= 1'b0;
                    cfg_done_reg <= 1'b1;
                end
                default: begin
                    state_reg <= RUN;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = ready_reg;
    assign in_ready  = ready_reg;
    assign busy      = busy_reg;
    assign delay     = delay_reg;
    assign cfg_done  = cfg_done_reg;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl: drain/switch timing, scoreboarded sparse traffic,
// equal-delay requests, reset during drain, and the no-drain variant.
module tb_delay_line_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cfg_delay;
    logic       cfg_valid, in_valid;
    logic       cfg_ready, in_ready, out_valid, busy, cfg_done;
    logic [3:0] delay;

    logic [3:0] nd_cfg_delay;
    logic       nd_cfg_valid, nd_in_valid;
    logic       nd_cfg_ready, nd_in_ready, nd_out_valid, nd_busy, nd_cfg_done;
    logic [3:0] nd_delay;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    delay_line_ctrl #(.DEFAULT_DELAY(0), .DRAIN_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_delay(cfg_delay), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .in_valid(in_valid), .in_ready(in_ready),
        .delay(delay), .out_valid(out_valid), .busy(busy), .cfg_done(cfg_done)
    );

    delay_line_ctrl #(.DEFAULT_DELAY(5), .DRAIN_EN(1'b0)) dut_nd (
        .clk(clk), .rst_n(rst_n), .cfg_delay(nd_cfg_delay), .cfg_valid(nd_cfg_valid),
        .cfg_ready(nd_cfg_ready), .in_valid(nd_in_valid), .in_ready(nd_in_ready),
        .delay(nd_delay), .out_valid(nd_out_valid), .busy(nd_busy), .cfg_done(nd_cfg_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Begin a cycle: inputs driven after this apply until the next rising edge.
    task automatic cycle_begin();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_delay(input logic [3:0] d);
        bit seen;
        cycle_begin();
        cfg_valid = 1'b1;
        cfg_delay = d;
        in_valid  = 1'b0;
        #1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle_begin();
            cfg_valid = 1'b0;
            #1;
            if (cfg_done) seen = 1'b1;
        end
        check_eq("setdly_done", 32'(seen), 32'd1);
        check_eq("setdly_delay", 32'(delay), 32'(d));
        $display("set_delay to %0d at cycle %0d", d, cyc);
    endtask

    initial begin
        int q[$];
        int n_emit;
        int mdl;
        bit exp_ov;

        rst_n = 1'b0;
        cfg_delay = '0; cfg_valid = 1'b0; in_valid = 1'b0;
        nd_cfg_delay = '0; nd_cfg_valid = 1'b0; nd_in_valid = 1'b0;

        // ---- reset state and delay 0 latency ----
        repeat (3) cycle_begin();
        #1;
        check_eq("rst_delay", 32'(delay), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_nd_delay", 32'(nd_delay), 32'd5);
        cycle_begin();
        rst_n = 1'b1;
        cycle_begin();
        in_valid = 1'b1;
        #1;
        check_eq("t1_ov_accept", 32'(out_valid), 32'd0);
        cycle_begin();
        in_valid = 1'b0;
        #1;
        check_eq("t1_ov_next", 32'(out_valid), 32'd1);
        cycle_begin();
        #1;
        check_eq("t1_ov_after", 32'(out_valid), 32'd0);
        $display("test1 delay0 pulse done at cycle %0d", cyc);

        // ---- delay 3 -> 7 with continuous traffic ----
        set_delay(4'd3);
        repeat (6) begin
            cycle_begin();
            in_valid = 1'b1;
        end
        for (int k = 0; k < 16; k++) begin
            cycle_begin();
            in_valid  = 1'b1;
            cfg_valid = (k <= 7);
            cfg_delay = 4'd7;
            #1;
            check_eq("t2_in_ready", 32'(in_ready), 32'((k >= 1 && k <= 6) ? 0 : 1));
            check_eq("t2_busy", 32'(busy), 32'((k >= 1 && k <= 6) ? 1 : 0));
            check_eq("t2_out_valid", 32'(out_valid), 32'((k <= 4 || k == 15) ? 1 : 0));
            check_eq("t2_delay", 32'(delay), 32'((k <= 6) ? 3 : 7));
            check_eq("t2_cfg_done", 32'(cfg_done), 32'((k == 7) ? 1 : 0));
        end
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        $display("test2 delay 3->7 done at cycle %0d", cyc);

        // ---- delay 9 -> 2 with sparse traffic and a timing scoreboard ----
        set_delay(4'd9);
        n_emit = 0;
        for (int n = 0; n < 60; n++) begin
            cycle_begin();
            in_valid  = (n % 3 == 0) && (n < 45);
            cfg_valid = (n == 10);
            cfg_delay = 4'd2;
            #1;
            check_eq("t3_in_ready", 32'(in_ready), 32'((n >= 11 && n <= 21) ? 0 : 1));
            mdl = (n >= 22) ? 2 : 9;
            if (in_valid && (n < 12 || n > 21)) q.push_back(n + 1 + mdl);
            exp_ov = (q.size() > 0) && (q[0] == n);
            check_eq("t3_out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) begin
                void'(q.pop_front());
                n_emit++;
            end
        end
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
        check_eq("t3_emitted", 32'(n_emit), 32'd11);
        check_eq("t3_queue_empty", 32'(q.size()), 32'd0);
        check_eq("t3_delay", 32'(delay), 32'd2);
        $display("test3 delay 9->2 sparse done, emitted=%0d", n_emit);

        // ---- request equal to current delay ----
        cycle_begin();
        cfg_valid = 1'b1;
        cfg_delay = 4'd2;
        #1;
        check_eq("t4_cfg_ready", 32'(cfg_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cycle_begin();
            cfg_valid = 1'b0;
            #1;
            check_eq("t4_in_ready", 32'(in_ready), 32'd1);
            check_eq("t4_busy", 32'(busy), 32'd0);
            check_eq("t4_cfg_done", 32'(cfg_done), 32'd0);
            check_eq("t4_delay", 32'(delay), 32'd2);
        end
        $display("test4 equal-delay request done at cycle %0d", cyc);

        // ---- reset during drain ----
        set_delay(4'd12);
        repeat (5) begin
            cycle_begin();
            in_valid = 1'b1;
        end
        cycle_begin();
        cfg_valid = 1'b1;
        cfg_delay = 4'd4;
        cycle_begin();
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        #1;
        check_eq("t5_busy_drain", 32'(busy), 32'd1);
        cycle_begin();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_delay", 32'(delay), 32'd0);
        check_eq("t5_out_valid", 32'(out_valid), 32'd0);
        check_eq("t5_in_ready", 32'(in_ready), 32'd1);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_nd_delay", 32'(nd_delay), 32'd5);
        cycle_begin();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle_begin();
            #1;
            check_eq("t5_no_done", 32'(cfg_done), 32'd0);
            check_eq("t5_delay_hold", 32'(delay), 32'd0);
        end
        $display("test5 reset mid-drain done at cycle %0d", cyc);

        // ---- no-drain variant: delay 5 -> 10 with samples in flight ----
        for (int k = 0; k < 18; k++) begin
            cycle_begin();
            nd_in_valid  = (k <= 2) || (k == 4);
            nd_cfg_valid = (k == 2);
            nd_cfg_delay = 4'd10;
            #1;
            check_eq("t6_busy", 32'(nd_busy), 32'((k == 3) ? 1 : 0));
            check_eq("t6_in_ready", 32'(nd_in_ready), 32'((k == 3) ? 0 : 1));
            check_eq("t6_delay", 32'(nd_delay), 32'((k <= 3) ? 5 : 10));
            check_eq("t6_cfg_done", 32'(nd_cfg_done), 32'((k == 4) ? 1 : 0));
            check_eq("t6_out_valid", 32'(nd_out_valid), 32'((k == 15) ? 1 : 0));
        end
        nd_in_valid  = 1'b0;
        nd_cfg_valid = 1'b0;
        $display("test6 no-drain switch done at cycle %0d", cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
